// File: rtl/periph_bus_fabric_if.sv
// ============================================================================
//  Module   : periph_bus_fabric_if
//  Purpose  : CPU request/response and slave-side signal bundle for the
//             peripheral bus fabric. The "slave" modport is the fabric's
//             view; the "master" modport is the environment (CPU data port
//             plus the peripherals) that drives the fabric.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface periph_bus_fabric_if #(
   parameter int N_SLV = 3,
   parameter int AW    = 32,
   parameter int DW    = 32
);
   // CPU request side
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [AW-1:0]        req_addr;
   logic [DW-1:0]        req_wdata;
   // CPU response side
   logic                 resp_valid;
   logic [DW-1:0]        resp_rdata;
   logic                 resp_err;
   // Slave side
   logic [N_SLV-1:0]     slv_sel;
   logic                 slv_we;
   logic [AW-1:0]        slv_addr;
   logic [DW-1:0]        slv_wdata;
   logic [N_SLV*DW-1:0]  slv_rdata;
   logic [N_SLV-1:0]     slv_ready;
   // Error log
   logic                 err_valid;
   logic [AW-1:0]        err_addr;
   logic                 err_timeout;
   logic                 err_clr;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      input  slv_rdata, slv_ready, err_clr,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output slv_sel, slv_we, slv_addr, slv_wdata,
      output err_valid, err_addr, err_timeout
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      output slv_rdata, slv_ready, err_clr,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  slv_sel, slv_we, slv_addr, slv_wdata,
      input  err_valid, err_addr, err_timeout
   );
endinterface

`default_nettype wire

// File: rtl/periph_bus_fabric.sv
// ============================================================================
//  Module   : periph_bus_fabric
//  Purpose  : Registered single-master peripheral interconnect. Decodes the
//             CPU address against N base/mask slave windows, runs a
//             valid/ready access with slave wait states, answers unmapped
//             addresses with an error response and keeps a sticky log of
//             the first error seen.
//  Options  : FABRIC_TIMEOUT_EN - when defined, a wait-state watchdog ends
//             an access with an error after TIMEOUT cycles without ready.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module periph_bus_fabric #(
   parameter int                    N_SLV    = 3,
   parameter int                    AW       = 32,
   parameter int                    DW       = 32,
   parameter logic [N_SLV*AW-1:0]   SLV_BASE = {32'h0000_1008, 32'h0000_1000, 32'h0000_0000},
   parameter logic [N_SLV*AW-1:0]   SLV_MASK = {32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_F000},
   parameter int                    TIMEOUT  = 16
) (
   input  wire logic                clk,
   input  wire logic                rst_n,
   periph_bus_fabric_if.slave       bus
);

   // Elaboration-time sanity checks on the configuration
   if (N_SLV < 1 || N_SLV > 16) begin : g_bad_nslv
      $error("periph_bus_fabric: N_SLV must be in 1..16");
   end
   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("periph_bus_fabric: TIMEOUT must be at least 2");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [N_SLV-1:0]    sel_q, sel_d;
   logic                we_q, we_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic [DW-1:0]       wdata_q, wdata_d;
   logic [DW-1:0]       rdata_q, rdata_d;
   logic                rerr_q, rerr_d;
   logic                errv_q, errv_d;
   logic [AW-1:0]       erra_q, erra_d;
   logic                errt_q, errt_d;

   // Error reporting from the FSM into the log
   logic                log_set;
   logic [AW-1:0]       log_addr;
   logic                log_to;

   // Address decode: one match bit per window
   logic [N_SLV-1:0]    dec_match;
   logic [N_SLV-1:0]    dec_sel;
   logic                dec_hit;

   for (genvar i = 0; i < N_SLV; i++) begin : g_dec
      assign dec_match[i] = ((bus.req_addr & SLV_MASK[i*AW +: AW]) ==
                             (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]));
   end

   // Isolating the lowest set bit gives lowest-index priority on overlaps
   assign dec_sel = dec_match & (~dec_match + N_SLV'(1));
   assign dec_hit = |dec_match;

   // Read data of the selected slave; sel_q is one-hot so an AND-OR mux suffices
   logic [DW-1:0]       rd_acc [N_SLV+1];
   assign rd_acc[0] = '0;
   for (genvar i = 0; i < N_SLV; i++) begin : g_rd
      assign rd_acc[i+1] = rd_acc[i] | ({DW{sel_q[i]}} & bus.slv_rdata[i*DW +: DW]);
   end

   logic                sel_ready;
   assign sel_ready = |(bus.slv_ready & sel_q);

`ifdef FABRIC_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                cnt_done;
   assign cnt_done = (cnt_q == CW'(TIMEOUT - 1));
`else
   logic                cnt_done;
   assign cnt_done = 1'b0;
`endif

   // Registers: FSM state, slave-side latches, response and error log
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         rerr_q  <= 1'b0;
         errv_q  <= 1'b0;
         erra_q  <= '0;
         errt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         rerr_q  <= rerr_d;
         errv_q  <= errv_d;
         erra_q  <= erra_d;
         errt_q  <= errt_d;
      end
   end

`ifdef FABRIC_TIMEOUT_EN
   // Wait-state counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   // Next-state and datapath: accept/decode in IDLE, complete or time out in WAIT
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      rerr_d   = rerr_q;
      log_set  = 1'b0;
      log_addr = addr_q;
      log_to   = 1'b0;
`ifdef FABRIC_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               if (dec_hit) begin
                  sel_d   = dec_sel;
                  we_d    = bus.req_write;
                  addr_d  = bus.req_addr;
                  wdata_d = bus.req_wdata;
`ifdef FABRIC_TIMEOUT_EN
                  cnt_d   = '0;
`endif
                  state_d = S_WAIT;
               end else begin
                  // Unmapped: answer straight away, no slave is touched
                  rerr_d   = 1'b1;
                  rdata_d  = '0;
                  log_set  = 1'b1;
                  log_addr = bus.req_addr;
                  state_d  = S_RESP;
               end
            end
         end
         S_WAIT: begin
            if (sel_ready) begin
               rdata_d = we_q ? '0 : rd_acc[N_SLV];
               rerr_d  = 1'b0;
               sel_d   = '0;
               we_d    = 1'b0;
               state_d = S_RESP;
            end else if (cnt_done) begin
               // Watchdog expiry: drop the slave and report a timeout
               sel_d    = '0;
               we_d     = 1'b0;
               rerr_d   = 1'b1;
               rdata_d  = '0;
               log_set  = 1'b1;
               log_addr = addr_q;
               log_to   = 1'b1;
               state_d  = S_RESP;
            end else begin
`ifdef FABRIC_TIMEOUT_EN
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Error log: first error sticks; a clear in the same cycle as a new error lets it in
   always_comb begin
      errv_d = errv_q;
      erra_d = erra_q;
      errt_d = errt_q;
      if (log_set) begin
         errv_d = 1'b1;
         if (!errv_q || bus.err_clr) begin
            erra_d = log_addr;
            errt_d = log_to;
         end
      end else if (bus.err_clr) begin
         errv_d = 1'b0;
      end
   end

   assign bus.req_ready   = (state_q == S_IDLE);
   assign bus.resp_valid  = (state_q == S_RESP);
   assign bus.resp_rdata  = rdata_q;
   assign bus.resp_err    = rerr_q;
   assign bus.slv_sel     = sel_q;
   assign bus.slv_we      = we_q;
   assign bus.slv_addr    = addr_q;
   assign bus.slv_wdata   = wdata_q;
   assign bus.err_valid   = errv_q;
   assign bus.err_addr    = erra_q;
   assign bus.err_timeout = errt_q;

endmodule

`default_nettype wire

// File: tb/tb_periph_bus_fabric.sv
// ============================================================================
//  Module   : tb_periph_bus_fabric
//  Purpose  : Directed self-checking bench for periph_bus_fabric.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_periph_bus_fabric;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   periph_bus_fabric_if #(.N_SLV(3), .AW(32), .DW(32)) bus ();

   periph_bus_fabric #(
      .N_SLV    (3),
      .AW       (32),
      .DW       (32),
      .SLV_BASE ({32'h0000_1008, 32'h0000_1000, 32'h0000_0000}),
      .SLV_MASK ({32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_F000}),
      .TIMEOUT  (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Step past the next rising edge; outputs are sampled and inputs changed here
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
   endtask

   logic [5:0] rv_seen;

   initial begin
      checks         = 0;
      errors         = 0;
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.slv_rdata  = {32'h2222_2222, 32'h1234_5678, 32'hDEAD_BEEF};
      bus.slv_ready  = '0;
      bus.err_clr    = 1'b0;

      // ---------------- reset state ----------------
      #12;
      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_slv_sel", 64'(bus.slv_sel), 64'd0);
      chk("rst_err_valid", 64'(bus.err_valid), 64'd0);
      chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
      rst_n = 1'b1;
      tick();

      // ---------------- zero-wait read from RAM ----------------
      request(1'b0, 32'h0000_0040, 32'h0);
      bus.slv_ready = 3'b001;
      tick();                                // accept edge k
      bus.req_valid = 1'b0;
      chk("rd_sel", 64'(bus.slv_sel), 64'b001);
      chk("rd_we", 64'(bus.slv_we), 64'd0);
      chk("rd_addr", 64'(bus.slv_addr), 64'h40);
      chk("rd_ready_busy", 64'(bus.req_ready), 64'd0);
      chk("rd_rv_early", 64'(bus.resp_valid), 64'd0);
      tick();                                // cycle k+2
      chk("rd_rv", 64'(bus.resp_valid), 64'd1);
      chk("rd_rdata", 64'(bus.resp_rdata), 64'hDEAD_BEEF);
      chk("rd_err", 64'(bus.resp_err), 64'd0);
      chk("rd_sel_clr", 64'(bus.slv_sel), 64'd0);
      tick();
      chk("rd_rv_one", 64'(bus.resp_valid), 64'd0);
      chk("rd_idle_ready", 64'(bus.req_ready), 64'd1);
      bus.slv_ready = 3'b000;

      // ---------------- GPIO write with 3 wait states ----------------
      request(1'b1, 32'h0000_1004, 32'h0000_00FF);
      tick();
      bus.req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("wr_sel", 64'(bus.slv_sel), 64'b010);
         chk("wr_we", 64'(bus.slv_we), 64'd1);
         chk("wr_ready_busy", 64'(bus.req_ready), 64'd0);
         chk("wr_rv_low", 64'(bus.resp_valid), 64'd0);
         // non-selected slaves signalling ready must be ignored
         bus.slv_ready = (i == 3) ? 3'b010 : 3'b101;
         if (i < 3) tick();
      end
      chk("wr_wdata", 64'(bus.slv_wdata), 64'hFF);
      tick();
      bus.slv_ready = 3'b000;
      chk("wr_rv", 64'(bus.resp_valid), 64'd1);
      chk("wr_rdata_zero", 64'(bus.resp_rdata), 64'd0);
      chk("wr_err", 64'(bus.resp_err), 64'd0);
      chk("wr_sel_clr", 64'(bus.slv_sel), 64'd0);
      chk("wr_we_clr", 64'(bus.slv_we), 64'd0);
      chk("wr_ready_resp", 64'(bus.req_ready), 64'd0);
      tick();

      // ---------------- unmapped read ----------------
      request(1'b0, 32'h0000_2000, 32'h0);
      tick();
      bus.req_valid = 1'b0;
      chk("um_rv", 64'(bus.resp_valid), 64'd1);
      chk("um_err", 64'(bus.resp_err), 64'd1);
      chk("um_rdata", 64'(bus.resp_rdata), 64'd0);
      chk("um_sel", 64'(bus.slv_sel), 64'd0);
      chk("um_err_valid", 64'(bus.err_valid), 64'd1);
      chk("um_err_addr", 64'(bus.err_addr), 64'h2000);
      chk("um_err_to", 64'(bus.err_timeout), 64'd0);
      tick();
      chk("um_idle", 64'(bus.req_ready), 64'd1);

      // clear the log on its own
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      chk("clr_err_valid", 64'(bus.err_valid), 64'd0);

      // ---------------- slave never ready ----------------
      request(1'b1, 32'h0000_1008, 32'hA5A5_0000);
      tick();
      bus.req_valid = 1'b0;
`ifdef FABRIC_TIMEOUT_EN
      for (int i = 0; i < 16; i++) begin
         chk("to_sel_held", 64'(bus.slv_sel), 64'b100);
         if (i < 15) tick();
      end
      tick();
      chk("to_sel_clr", 64'(bus.slv_sel), 64'd0);
      chk("to_rv", 64'(bus.resp_valid), 64'd1);
      chk("to_err", 64'(bus.resp_err), 64'd1);
      chk("to_err_valid", 64'(bus.err_valid), 64'd1);
      chk("to_err_addr", 64'(bus.err_addr), 64'h1008);
      chk("to_err_to", 64'(bus.err_timeout), 64'd1);
      tick();
`else
      for (int i = 0; i < 20; i++) begin
         chk("nowd_sel_held", 64'(bus.slv_sel), 64'b100);
         tick();
      end
      chk("nowd_rv_low", 64'(bus.resp_valid), 64'd0);
      bus.slv_ready = 3'b100;
      tick();
      bus.slv_ready = 3'b000;
      chk("nowd_rv", 64'(bus.resp_valid), 64'd1);
      chk("nowd_err", 64'(bus.resp_err), 64'd0);
      chk("nowd_err_valid", 64'(bus.err_valid), 64'd0);
      tick();
`endif
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;

      // ---------------- sticky log: first error kept, clear+set loads new ----------------
      request(1'b0, 32'h0000_3000, 32'h0);
      tick();
      bus.req_valid = 1'b0;
      chk("log1_addr", 64'(bus.err_addr), 64'h3000);
      tick();
      request(1'b0, 32'h0000_4000, 32'h0);
      tick();
      bus.req_valid = 1'b0;
      chk("log2_valid", 64'(bus.err_valid), 64'd1);
      chk("log2_addr_kept", 64'(bus.err_addr), 64'h3000);
      tick();
      request(1'b0, 32'h0000_5000, 32'h0);
      bus.err_clr = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      bus.err_clr   = 1'b0;
      chk("log3_valid", 64'(bus.err_valid), 64'd1);
      chk("log3_addr", 64'(bus.err_addr), 64'h5000);
      chk("log3_to", 64'(bus.err_timeout), 64'd0);
      tick();

      // ---------------- back-to-back: one access per 3 cycles ----------------
      request(1'b0, 32'h0000_0080, 32'h0);
      bus.slv_ready = 3'b001;
      for (int i = 0; i < 6; i++) begin
         tick();
         rv_seen[i] = bus.resp_valid;
      end
      bus.req_valid = 1'b0;
      bus.slv_ready = 3'b000;
      chk("b2b_pattern", 64'(rv_seen), 64'b010010);
      tick();
      tick();

      // ---------------- asynchronous reset during WAIT ----------------
      request(1'b0, 32'h0000_1000, 32'h0);
      tick();
      bus.req_valid = 1'b0;
      chk("ar_sel_before", 64'(bus.slv_sel), 64'b010);
      chk("ar_errv_before", 64'(bus.err_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_sel", 64'(bus.slv_sel), 64'd0);
      chk("ar_rv", 64'(bus.resp_valid), 64'd0);
      chk("ar_err_valid", 64'(bus.err_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("ar_ready_after", 64'(bus.req_ready), 64'd1);
      chk("ar_rv_after", 64'(bus.resp_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
